instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-002 Parameter: RESET_PC, 64'h0, PC value loaded on reset.
REQ-003 Ports SHALL be, clock and reset first:
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- pc_src_i  in  1  branch taken; redirect the PC
- branch_pc_i  in  64  redirect target
- pc_en_i  in  1  PC update and new request enable; low = stall
- if_en_i  in  1  IF/ID register load enable; low = hold
- flush_i  in  1  kill the IF/ID contents
- imem_req_o  out  1  fetch request
- imem_addr_o  out  64  fetch address
- imem_gnt_i  in  1  request accepted
- imem_rvalid_i  in  1  response valid
- imem_rdata_i  in  32  response instruction
- instr_o  out  32  IF/ID instruction
- pc_o  out  64  IF/ID PC of instr_o
- valid_o  out  1  IF/ID holds a live instruction
- fetch_cnt_o  out  32  delivered-instruction counter
- drop_cnt_o  out  32  discarded-response counter

Function
REQ-004 The block SHALL allow at most one memory request outstanding.
REQ-005 The FSM states SHALL be REQ, WAIT, HOLD and DROP.
- REQ: imem_req_o = pc_en_i; imem_addr_o = PC.
- imem_req_o and imem_gnt_i both high moves REQ to WAIT.
- The address of the granted request SHALL be latched as fetch_pc.
REQ-006 WAIT, imem_rvalid_i high, if_en_i high:
- instr_o <= imem_rdata_i; pc_o <= fetch_pc; valid_o <= 1.
- PC <= fetch_pc+4, wrapping modulo 2^64.
- Next state REQ.
REQ-007 WAIT, imem_rvalid_i high, if_en_i low:
- The response SHALL be stored in a one-entry hold buffer.
- PC <= fetch_pc+4; next state HOLD; IF/ID unchanged.
REQ-008 HOLD with if_en_i high SHALL move the buffer to the IF/ID register with valid_o <= 1, then go to REQ.
- HOLD with if_en_i low SHALL hold all state.
REQ-009 With if_en_i high and no new instruction loaded that cycle, valid_o SHALL go to 0 (bubble).
- With if_en_i low, instr_o, pc_o and valid_o SHALL hold.
REQ-010 pc_src_i high SHALL set PC <= {branch_pc_i[63:2],2'b00}, clear valid_o and clear the hold buffer. Next state by case:
- From REQ with no grant: REQ, using the new address next cycle.
- From REQ with a grant, or from WAIT without imem_rvalid_i: DROP.
- From WAIT with imem_rvalid_i: REQ, response discarded.
- From HOLD: REQ.
REQ-011 DROP SHALL discard the next imem_rvalid_i response, write nothing, increment drop_cnt_o, then go to REQ.
REQ-012 flush_i high without pc_src_i SHALL clear valid_o and the hold buffer.
- A response arriving the same cycle SHALL be discarded; PC stays at fetch_pc, so the same address is refetched.
- From HOLD, the next state SHALL be REQ.
REQ-013 Priority SHALL be: reset > pc_src_i > flush_i > if_en_i/pc_en_i.
- pc_src_i overrides pc_en_i low.
REQ-014 pc_en_i low in REQ SHALL deassert imem_req_o and freeze PC.
- An in-flight response SHALL still complete per REQ-006/007.

Reset
REQ-015 On rst_n_i low, asynchronously:
- PC = RESET_PC; state = REQ; valid_o = 0.
- instr_o = 32'h0000_0013 (NOP); pc_o = 0.
- hold buffer empty; counters = 0.
REQ-016 A response for a request granted before reset SHALL be ignored if it arrives after reset release.
- imem_req_o SHALL stay low during the first cycle after release.

Configuration
REQ-017 Macro IF_PERF_CNT_EN defined: counters are implemented.
- fetch_cnt_o increments once per valid_o load.
- drop_cnt_o increments once per discarded response.
- Both saturate at 32'hFFFF_FFFF.
REQ-018 Macro IF_PERF_CNT_EN undefined: fetch_cnt_o and drop_cnt_o SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-019 Reset with RESET_PC=64'h1000, memory granting and responding every cycle -> imem_addr_o 1000, 1004, 1008; pc_o/instr_o follow with valid_o=1.
REQ-020 if_en_i low 3 cycles as a response arrives -> IF/ID holds; on release the buffered instruction appears with correct pc_o; no refetch of that address.
REQ-021 pc_src_i=1 with branch_pc_i=64'h2002 while in WAIT -> the next response is dropped; drop_cnt_o=1; next imem_addr_o=64'h2000; valid_o=0 until the 2000 fetch returns.
REQ-022 flush_i=1 with imem_rvalid_i=1 at PC 64'h1010 -> valid_o=0; next imem_addr_o=64'h1010.
REQ-023 PC=64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr_o=64'h0; pc_en_i low 2 cycles -> imem_req_o low and PC unchanged.
REQ-024 rst_n_i asserted while in WAIT, stale rvalid after release -> ignored; valid_o=0; first new request at RESET_PC; counters 0 (IF_PERF_CNT_EN builds) or constant 0 (without).

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding IMEM requester feeding the IF/ID register.
// Performance counters are built only when IF_PERF_CNT_EN is defined.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pc_src_i,
  input  logic [63:0] branch_pc_i,
  input  logic        pc_en_i,
  input  logic        if_en_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] drop_cnt_o
);
  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2, DROP = 2'd3} state_t;

  // state is the FSM debug view; HOLD means the one-entry hold buffer is full.
  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [63:0] fetch_pc;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic [31:0] instr_q;
  logic [63:0] pc_q;
  logic        valid_q;
  logic        req_ok;
  logic        granted;
  logic        load_id;
  logic [31:0] load_instr;
  logic [63:0] branch_target;

  // Handshake: an address transfers when imem_req_o and imem_gnt_i are high in the same
  // cycle; the single outstanding response returns later as an imem_rvalid_i pulse with
  // no back-pressure, so the FSM must always be able to absorb or discard it.
  assign branch_target = branch_pc_i & ~64'h3;
  assign imem_req_o    = (state == REQ) && pc_en_i && req_ok;
  assign imem_addr_o   = pc;
  assign granted       = imem_req_o && imem_gnt_i;

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    hold_instr_nxt = hold_instr;
    load_id        = 1'b0;
    load_instr     = imem_rdata_i;
    if (pc_src_i) begin
      pc_nxt = branch_target;
      unique case (state)
        REQ:  state_nxt = granted ? DROP : REQ;
        WAIT: state_nxt = imem_rvalid_i ? REQ : DROP;
        HOLD: state_nxt = REQ;
        DROP: state_nxt = imem_rvalid_i ? REQ : DROP;
      endcase
    end else if (flush_i) begin
      // PC is not advanced, so a discarded or buffered instruction is fetched again.
      unique case (state)
        REQ:        if (granted) state_nxt = WAIT;
        WAIT, DROP: if (imem_rvalid_i) state_nxt = REQ;
        HOLD: begin
          state_nxt = REQ;
          pc_nxt    = fetch_pc;
        end
      endcase
    end else begin
      unique case (state)
        REQ: if (granted) state_nxt = WAIT;
        WAIT: begin
          if (imem_rvalid_i) begin
            pc_nxt = fetch_pc + 64'd4;
            if (if_en_i) begin
              load_id   = 1'b1;
              state_nxt = REQ;
            end else begin
              hold_instr_nxt = imem_rdata_i;
              state_nxt      = HOLD;
            end
          end
        end
        HOLD: begin
          if (if_en_i) begin
            load_id    = 1'b1;
            load_instr = hold_instr;
            state_nxt  = REQ;
          end
        end
        DROP: if (imem_rvalid_i) state_nxt = REQ;
      endcase
    end
  end

  // req_ok keeps the request low for the first cycle after reset release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= REQ;
      pc         <= RESET_PC;
      fetch_pc   <= RESET_PC;
      hold_instr <= '0;
      req_ok     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold_instr <= hold_instr_nxt;
      req_ok     <= 1'b1;
      if (granted) fetch_pc <= pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_q <= 32'h0000_0013;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (pc_src_i || flush_i) begin
      valid_q <= 1'b0;
    end else if (load_id) begin
      instr_q <= load_instr;
      pc_q    <= fetch_pc;
      valid_q <= 1'b1;
    end else if (if_en_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, drop_cnt;
  logic        drop_evt;

  assign drop_evt = imem_rvalid_i &&
                    ((state == DROP) || ((state == WAIT) && (pc_src_i || flush_i)));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (load_id && (fetch_cnt != 32'hFFFF_FFFF)) fetch_cnt <= fetch_cnt + 32'd1;
      if (drop_evt && (drop_cnt != 32'hFFFF_FFFF)) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt;
  assign drop_cnt_o  = drop_cnt;
`else
  assign fetch_cnt_o = '0;
  assign drop_cnt_o  = '0;
`endif

endmodule
